mbus_layer_msg_engine_testbench: RTL and testbench

- Layer-side counterpart of the MBus node's layer interface in the testbench environment.
- Drives TX_ADDR/TX_DATA/TX_REQ/TX_PEND/TX_PRIORITY/TX_RESP_ACK and completes the TX_ACK, TX_SUCC/TX_FAIL handshakes for multi-word messages from a preloaded word buffer.
- Answers RX_REQ with RX_ACK and assembles received words into a readable buffer.
- Sits between the bench stimulus and the master/member wrapper layer ports; TX and RX engines run independently.

---
 rtl/mbus_layer_msg_engine_testbench.sv | 235 +++++++++++++++++++++++
 tb/tb_mbus_layer_msg_engine_testbench.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbus_layer_msg_engine_testbench.sv
// Layer-side message engine for the MBus node layer port: sends multi-word messages from a
// preloaded TX buffer, and acknowledges and stores incoming words in an RX buffer.
module mbus_layer_msg_engine_testbench #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  TXB_CLR,
  input  logic                  TXB_WR,
  input  logic [DATA_WIDTH-1:0] TXB_WDATA,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] START_ADDR,
  input  logic [CNT_WIDTH-1:0]  START_LEN,
  input  logic                  START_PRIORITY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  DONE_SUCC,
  output logic                  DONE_FAIL,
  output logic [ADDR_WIDTH-1:0] TX_ADDR,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_REQ,
  output logic                  TX_PEND,
  output logic                  TX_PRIORITY,
  output logic                  TX_RESP_ACK,
  input  logic                  TX_ACK,
  input  logic                  TX_SUCC,
  input  logic                  TX_FAIL,
  input  logic [ADDR_WIDTH-1:0] RX_ADDR,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_REQ,
  input  logic                  RX_PEND,
  input  logic                  RX_BROADCAST,
  input  logic                  RX_FAIL,
  output logic                  RX_ACK,
  input  logic [CNT_WIDTH-1:0]  RXB_RD_IDX,
  output logic [DATA_WIDTH-1:0] RXB_RDATA,
  output logic                  RX_MSG_DONE,
  output logic [ADDR_WIDTH-1:0] RX_MSG_ADDR,
  output logic [CNT_WIDTH-1:0]  RX_MSG_LEN,
  output logic                  RX_MSG_BCAST,
  output logic                  RX_MSG_FAIL,
  output logic                  RX_MSG_OVF
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  typedef enum logic [2:0] {T_IDLE, T_REQ, T_ACKLOW, T_RESP, T_RACK} tx_state_t;
  typedef enum logic {R_IDLE, R_ACK} rx_state_t;

  // ---------------- TX buffer ----------------
  logic [DATA_WIDTH-1:0] tx_buf [DEPTH];
  logic [CNT_WIDTH-1:0]  wr_ptr;
  logic                  txb_we;

  assign txb_we = !TXB_CLR && TXB_WR && !BUSY && (wr_ptr < DEPTH_C);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)      wr_ptr <= '0;
    else if (TXB_CLR) wr_ptr <= '0;
    else if (txb_we)  wr_ptr <= wr_ptr + 1'b1;
  end

  // NOTE: buffer arrays carry no reset so they stay plain storage; contents survive RESETn.
  always_ff @(posedge CLK) begin
    if (txb_we) tx_buf[wr_ptr[IDX_W-1:0]] <= TXB_WDATA;
  end

  // ---------------- TX engine ----------------
  tx_state_t             tx_state, tx_next;
  logic [CNT_WIDTH-1:0]  tx_idx, tx_len;
  logic [ADDR_WIDTH-1:0] tx_addr_q;
  logic                  tx_prio_q, done_q, succ_q, fail_q;
  logic                  accept, tx_last, word_phase, idx_inc, res_latch, done_set;

  assign accept     = (tx_state == T_IDLE) && START && (START_LEN != '0) && (START_LEN <= DEPTH_C);
  assign tx_last    = (tx_idx == tx_len - 1'b1);
  assign word_phase = (tx_state == T_REQ) || (tx_state == T_ACKLOW);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    tx_next   = tx_state;
    idx_inc   = 1'b0;
    res_latch = 1'b0;
    done_set  = 1'b0;
    unique case (tx_state)
      T_IDLE: if (accept) tx_next = T_REQ;
      T_REQ: begin
        if (TX_FAIL || TX_SUCC) begin
          tx_next   = T_RACK;
          res_latch = 1'b1;
        end else if (TX_ACK) begin
          tx_next = T_ACKLOW;
        end
      end
      T_ACKLOW: begin
        if (TX_FAIL || TX_SUCC) begin
          tx_next   = T_RACK;
          res_latch = 1'b1;
        end else if (!TX_ACK) begin
          if (tx_last) begin
            tx_next = T_RESP;
          end else begin
            tx_next = T_REQ;
            idx_inc = 1'b1;
          end
        end
      end
      T_RESP: begin
        if (TX_FAIL || TX_SUCC) begin
          tx_next   = T_RACK;
          res_latch = 1'b1;
        end
      end
      T_RACK: begin
        if (!TX_SUCC && !TX_FAIL) begin
          tx_next  = T_IDLE;
          done_set = 1'b1;
        end
      end
      default: tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      tx_state  <= T_IDLE;
      tx_idx    <= '0;
      tx_len    <= '0;
      tx_addr_q <= '0;
      tx_prio_q <= 1'b0;
      done_q    <= 1'b0;
      succ_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      tx_state <= tx_next;
      done_q   <= done_set;
      if (accept) begin
        tx_idx    <= '0;
        tx_len    <= START_LEN;
        tx_addr_q <= START_ADDR;
        tx_prio_q <= START_PRIORITY;
        succ_q    <= 1'b0;
        fail_q    <= 1'b0;
      end
      if (idx_inc) tx_idx <= tx_idx + 1'b1;
      // A fail wins if the node ever raises both result lines together.
      if (res_latch) begin
        fail_q <= TX_FAIL;
        succ_q <= !TX_FAIL;
      end
    end
  end

  assign BUSY        = (tx_state != T_IDLE);
  assign DONE        = done_q;
  assign DONE_SUCC   = succ_q;
  assign DONE_FAIL   = fail_q;
  assign TX_REQ      = (tx_state == T_REQ);
  assign TX_RESP_ACK = (tx_state == T_RACK);
  assign TX_ADDR     = BUSY ? tx_addr_q : '0;
  assign TX_PRIORITY = BUSY && tx_prio_q;
  assign TX_DATA     = word_phase ? tx_buf[tx_idx[IDX_W-1:0]] : '0;
  assign TX_PEND     = word_phase && !tx_last;

  // ---------------- RX engine ----------------
  rx_state_t             rx_state, rx_next;
  logic [DATA_WIDTH-1:0] rx_buf [DEPTH];
  logic [CNT_WIDTH-1:0]  len_q, len_base;
  logic [ADDR_WIDTH-1:0] msg_addr_q;
  logic                  in_msg, end_q, rx_done_q, bcast_q, rx_fail_q, ovf_q;
  logic                  rx_start, rx_word, rx_store, rx_end;

  assign rx_start = (rx_state == R_IDLE) && (RX_REQ || RX_FAIL);
  assign rx_word  = RX_REQ && !RX_FAIL;
  assign len_base = in_msg ? len_q : '0;
  assign rx_store = rx_start && rx_word && (len_base < DEPTH_C);
  assign rx_end   = RX_FAIL || !RX_PEND;

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      R_IDLE:  if (RX_REQ || RX_FAIL) rx_next = R_ACK;
      R_ACK:   if (!RX_REQ && !RX_FAIL) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rx_state   <= R_IDLE;
      in_msg     <= 1'b0;
      end_q      <= 1'b0;
      rx_done_q  <= 1'b0;
      len_q      <= '0;
      msg_addr_q <= '0;
      bcast_q    <= 1'b0;
      rx_fail_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rx_state  <= rx_next;
      rx_done_q <= (rx_state == R_ACK) && (rx_next == R_IDLE) && end_q;
      if (rx_start) begin
        if (!in_msg) begin
          msg_addr_q <= RX_ADDR;
          bcast_q    <= RX_BROADCAST;
          ovf_q      <= 1'b0;
        end
        rx_fail_q <= RX_FAIL;
        len_q     <= rx_store ? len_base + 1'b1 : len_base;
        if (rx_word && (len_base >= DEPTH_C)) ovf_q <= 1'b1;
        end_q  <= rx_end;
        in_msg <= !rx_end;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rx_store) rx_buf[len_base[IDX_W-1:0]] <= RX_DATA;
  end

  assign RX_ACK       = (rx_state == R_ACK);
  assign RX_MSG_DONE  = rx_done_q;
  assign RX_MSG_ADDR  = msg_addr_q;
  assign RX_MSG_LEN   = len_q;
  assign RX_MSG_BCAST = bcast_q;
  assign RX_MSG_FAIL  = rx_fail_q;
  assign RX_MSG_OVF   = ovf_q;
  assign RXB_RDATA    = (RXB_RD_IDX < DEPTH_C) ? rx_buf[RXB_RD_IDX[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_mbus_layer_msg_engine_testbench.sv
// Bench for the layer message engine: plays the node side of both handshakes with randomized
// timing and checks against a transaction-level model of the TX buffer and RX message contents.
module tb_mbus_layer_msg_engine_testbench;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          TXB_CLR = 1'b0, TXB_WR = 1'b0;
  logic [DW-1:0] TXB_WDATA = '0;
  logic          START = 1'b0;
  logic [AW-1:0] START_ADDR = '0;
  logic [CW-1:0] START_LEN = '0;
  logic          START_PRIORITY = 1'b0;
  logic          TX_ACK = 1'b0, TX_SUCC = 1'b0, TX_FAIL = 1'b0;
  logic [AW-1:0] RX_ADDR = '0;
  logic [DW-1:0] RX_DATA = '0;
  logic          RX_REQ = 1'b0, RX_PEND = 1'b0, RX_BROADCAST = 1'b0, RX_FAIL = 1'b0;
  logic [CW-1:0] RXB_RD_IDX = '0;

  logic          BUSY, DONE, DONE_SUCC, DONE_FAIL;
  logic [AW-1:0] TX_ADDR;
  logic [DW-1:0] TX_DATA;
  logic          TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK, RX_ACK;
  logic [DW-1:0] RXB_RDATA;
  logic          RX_MSG_DONE, RX_MSG_BCAST, RX_MSG_FAIL, RX_MSG_OVF;
  logic [AW-1:0] RX_MSG_ADDR;
  logic [CW-1:0] RX_MSG_LEN;

  mbus_layer_msg_engine_testbench #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RESETn(RESETn),
    .TXB_CLR(TXB_CLR), .TXB_WR(TXB_WR), .TXB_WDATA(TXB_WDATA),
    .START(START), .START_ADDR(START_ADDR), .START_LEN(START_LEN), .START_PRIORITY(START_PRIORITY),
    .BUSY(BUSY), .DONE(DONE), .DONE_SUCC(DONE_SUCC), .DONE_FAIL(DONE_FAIL),
    .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_REQ(TX_REQ), .TX_PEND(TX_PEND),
    .TX_PRIORITY(TX_PRIORITY), .TX_RESP_ACK(TX_RESP_ACK),
    .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
    .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA), .RX_REQ(RX_REQ), .RX_PEND(RX_PEND),
    .RX_BROADCAST(RX_BROADCAST), .RX_FAIL(RX_FAIL), .RX_ACK(RX_ACK),
    .RXB_RD_IDX(RXB_RD_IDX), .RXB_RDATA(RXB_RDATA),
    .RX_MSG_DONE(RX_MSG_DONE), .RX_MSG_ADDR(RX_MSG_ADDR), .RX_MSG_LEN(RX_MSG_LEN),
    .RX_MSG_BCAST(RX_MSG_BCAST), .RX_MSG_FAIL(RX_MSG_FAIL), .RX_MSG_OVF(RX_MSG_OVF)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model state: TX buffer image, the message in flight, and what the node has seen.
  logic [DW-1:0] m_txbuf [DEPTH];
  int            m_ptr = 0;
  bit            tx_active = 1'b0, rx_active = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  bit            exp_prio = 1'b0;
  int            exp_word = 0, exp_len = 0;
  logic [DW-1:0] seen_data [$];
  logic          seen_pend [$];
  int            rx_done_cnt = 0;
  logic          req_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [DW-1:0] seen_at(input int i);
    if (i < seen_data.size()) return seen_data[i];
    return 'x;
  endfunction

  function automatic logic pend_at(input int i);
    if (i < seen_pend.size()) return seen_pend[i];
    return 1'bx;
  endfunction

  // Per-cycle comparison of the node-facing outputs against the model.
  always @(negedge CLK) begin
    if (!RESETn) begin
      req_prev <= 1'b0;
    end else begin
      if (TX_REQ) begin
        check("req_in_msg", {31'd0, tx_active}, 1);
        check("tx_addr", TX_ADDR, exp_addr);
        check("tx_prio", TX_PRIORITY, exp_prio);
        check("tx_busy", BUSY, 1);
        check("tx_data", TX_DATA, m_txbuf[exp_word]);
        check("tx_pend", TX_PEND, exp_word != exp_len - 1);
        if (!req_prev) begin
          seen_data.push_back(TX_DATA);
          seen_pend.push_back(TX_PEND);
        end
      end
      if (!tx_active) check("tx_quiet", {BUSY, DONE, TX_REQ, TX_RESP_ACK}, 0);
      if (!rx_active) check("rx_quiet", {RX_ACK, RX_MSG_DONE}, 0);
      if (RX_MSG_DONE) rx_done_cnt <= rx_done_cnt + 1;
      req_prev <= TX_REQ;
    end
  end

  task automatic txb_op(input bit clr, input bit wr, input logic [DW-1:0] d, input bit busy);
    TXB_CLR = clr;
    TXB_WR = wr;
    TXB_WDATA = d;
    tick();
    TXB_CLR = 1'b0;
    TXB_WR = 1'b0;
    if (clr) m_ptr = 0;
    else if (wr && !busy && m_ptr < DEPTH) begin
      m_txbuf[m_ptr] = d;
      m_ptr++;
    end
  endtask

  // Node side of one TX message. fail_word >= 0 aborts with TX_FAIL while that word is requested.
  task automatic tx_msg(input logic [AW-1:0] addr, input int len, input bit prio,
                        input int fail_word, input bit resp_fail);
    bit acc;
    acc = (len >= 1) && (len <= DEPTH);
    START_ADDR = addr;
    START_LEN = len[CW-1:0];
    START_PRIORITY = prio;
    START = 1'b1;
    if (acc) begin
      exp_addr = addr;
      exp_len = len;
      exp_prio = prio;
      exp_word = 0;
      seen_data.delete();
      seen_pend.delete();
      tx_active = 1'b1;
    end
    tick();
    START = 1'b0;
    check("start_busy", BUSY, acc);
    check("start_req", TX_REQ, acc);
    if (!acc) begin
      repeat (4) begin
        tick();
        check("rejected_quiet", {DONE, BUSY, TX_REQ}, 0);
      end
      return;
    end
    for (int w = 0; w < len; w++) begin
      exp_word = w;
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 2) == 0) txb_op(1'b0, 1'b1, $urandom, 1'b1);
        else tick();
        check("req_hold", TX_REQ, 1);
      end
      if (w == fail_word) begin
        TX_FAIL = 1'b1;
        tick();
        check("fail_req_drop", TX_REQ, 0);
        check("fail_rack", TX_RESP_ACK, 1);
        repeat ($urandom_range(0, 2)) begin
          tick();
          check("fail_rack_hold", TX_RESP_ACK, 1);
        end
        TX_FAIL = 1'b0;
        tick();
        check("fail_done", {DONE, DONE_SUCC, DONE_FAIL, TX_RESP_ACK, BUSY}, 5'b10100);
        tick();
        check("fail_after", {DONE, DONE_FAIL}, 2'b01);
        check("fail_words_seen", seen_data.size(), w + 1);
        tx_active = 1'b0;
        return;
      end
      TX_ACK = 1'b1;
      tick();
      check("ack_req_drop", TX_REQ, 0);
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("acklow_wait", TX_REQ, 0);
      end
      TX_ACK = 1'b0;
      tick();
      check("next_req", TX_REQ, w != len - 1);
    end
    repeat ($urandom_range(0, 3)) begin
      tick();
      check("resp_wait", {TX_RESP_ACK, BUSY, DONE}, 3'b010);
    end
    if (resp_fail) TX_FAIL = 1'b1;
    else TX_SUCC = 1'b1;
    tick();
    check("rack_rise", {TX_RESP_ACK, DONE}, 2'b10);
    repeat ($urandom_range(0, 2)) begin
      tick();
      check("rack_hold", TX_RESP_ACK, 1);
    end
    TX_SUCC = 1'b0;
    TX_FAIL = 1'b0;
    tick();
    check("done", {DONE, DONE_SUCC, DONE_FAIL, TX_RESP_ACK, BUSY}, {1'b1, !resp_fail, resp_fail, 2'b00});
    tick();
    check("done_pulse_end", {DONE, DONE_SUCC, DONE_FAIL}, {1'b0, !resp_fail, resp_fail});
    check("words_seen", seen_data.size(), len);
    tx_active = 1'b0;
  endtask

  // Node side of one RX message: n words of data d0 + i*step, optionally ended by RX_FAIL.
  task automatic rx_msg(input logic [AW-1:0] addr, input bit bcast, input int n, input bit fail_end,
                        input logic [DW-1:0] d0, input logic [DW-1:0] step);
    logic [DW-1:0] exp_rx [DEPTH];
    int            done_before, exp_n;
    done_before = rx_done_cnt;
    rx_active = 1'b1;
    RX_ADDR = addr;
    RX_BROADCAST = bcast;
    for (int i = 0; i < n; i++) begin
      RX_DATA = d0 + step * DW'(i);
      if (i < DEPTH) exp_rx[i] = RX_DATA;
      RX_PEND = fail_end || (i != n - 1);
      RX_REQ = 1'b1;
      tick();
      check("rx_ack_rise", RX_ACK, 1);
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("rx_ack_hold", RX_ACK, 1);
      end
      RX_REQ = 1'b0;
      tick();
      check("rx_ack_fall", RX_ACK, 0);
      check("rx_done_pulse", RX_MSG_DONE, !fail_end && (i == n - 1));
    end
    if (fail_end) begin
      RX_FAIL = 1'b1;
      tick();
      check("rx_fail_ack", RX_ACK, 1);
      RX_FAIL = 1'b0;
      tick();
      check("rx_fail_done", {RX_ACK, RX_MSG_DONE}, 2'b01);
    end
    tick();
    check("rx_done_end", RX_MSG_DONE, 0);
    check("rx_done_count", rx_done_cnt, done_before + 1);
    exp_n = (n > DEPTH) ? DEPTH : n;
    check("rx_len", RX_MSG_LEN, exp_n);
    check("rx_flags", {RX_MSG_BCAST, RX_MSG_FAIL, RX_MSG_OVF}, {bcast, fail_end, n > DEPTH});
    check("rx_addr", RX_MSG_ADDR, addr);
    for (int i = 0; i < exp_n; i++) begin
      RXB_RD_IDX = i[CW-1:0];
      #1;
      check("rx_buf", RXB_RDATA, exp_rx[i]);
    end
    rx_active = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] lit_d [3];
    logic [AW-1:0] ra;
    int            len, fw, n_wr, rn;
    bit            rf, rxf, rb;
    lit_d[0] = 32'hA1;
    lit_d[1] = 32'hB2;
    lit_d[2] = 32'hC3;

    repeat (2) @(posedge CLK);
    #1;
    check("reset_ctl", {BUSY, DONE, DONE_SUCC, DONE_FAIL, TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK,
                        RX_ACK, RX_MSG_DONE, RX_MSG_BCAST, RX_MSG_FAIL, RX_MSG_OVF}, 0);
    check("reset_vec", {TX_ADDR, TX_DATA}, 0);
    check("reset_rx", {RX_MSG_ADDR, RX_MSG_LEN}, 0);
    RESETn = 1'b1;
    tick();

    for (int i = 0; i < DEPTH; i++) txb_op(1'b0, 1'b1, $urandom, 1'b0);

    // Three-word message, node returns success.
    txb_op(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) txb_op(1'b0, 1'b1, lit_d[i], 1'b0);
    tx_msg(32'h50, 3, 1'b0, -1, 1'b0);
    for (int i = 0; i < 3; i++) check("lit_tx_data", seen_at(i), lit_d[i]);
    check("lit_tx_pend", {pend_at(0), pend_at(1), pend_at(2)}, 3'b110);

    // Illegal lengths are ignored.
    tx_msg(32'h51, 0, 1'b0, -1, 1'b0);
    tx_msg(32'h52, DEPTH + 1, 1'b0, -1, 1'b0);

    // Fail during word 2 of 4.
    tx_msg(32'h53, 4, 1'b1, 1, 1'b0);

    // Two-word broadcast RX.
    rx_msg(32'h0F, 1'b1, 2, 1'b0, 32'h11, 32'h11);
    RXB_RD_IDX = '0;
    #1 check("lit_rx0", RXB_RDATA, 32'h11);
    RXB_RD_IDX = 4'd1;
    #1 check("lit_rx1", RXB_RDATA, 32'h22);
    check("lit_rx_len", RX_MSG_LEN, 2);

    // RX overflow, and a message ended by RX_FAIL.
    rx_msg(32'h1234, 1'b0, DEPTH + 2, 1'b0, $urandom, $urandom);
    rx_msg(32'h77, 1'b0, 2, 1'b1, $urandom, $urandom);

    // Write pointer saturation and CLR-over-WR priority.
    txb_op(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) txb_op(1'b0, 1'b1, $urandom, 1'b0);
    tx_msg(32'h60, DEPTH, 1'b0, -1, 1'b1);
    txb_op(1'b1, 1'b1, 32'hDEAD, 1'b0);
    txb_op(1'b0, 1'b1, 32'h5A5A, 1'b0);
    tx_msg(32'h61, 2, 1'b0, -1, 1'b0);

    // Reset with TX_REQ and RX_ACK both high.
    tick();
    exp_addr = 32'h70;
    exp_len = 4;
    exp_prio = 1'b1;
    exp_word = 0;
    tx_active = 1'b1;
    START_ADDR = 32'h70;
    START_LEN = 4'd4;
    START_PRIORITY = 1'b1;
    START = 1'b1;
    RX_ADDR = 32'h99;
    RX_DATA = 32'h1;
    RX_PEND = 1'b1;
    RX_REQ = 1'b1;
    rx_active = 1'b1;
    tick();
    START = 1'b0;
    check("pre_reset", {TX_REQ, RX_ACK}, 2'b11);
    #2 RESETn = 1'b0;
    #1;
    check("mid_reset_ctl", {BUSY, DONE, DONE_SUCC, DONE_FAIL, TX_REQ, TX_PEND, TX_PRIORITY,
                            TX_RESP_ACK, RX_ACK, RX_MSG_DONE, RX_MSG_BCAST, RX_MSG_FAIL, RX_MSG_OVF}, 0);
    check("mid_reset_vec", {TX_ADDR, TX_DATA, RX_MSG_ADDR}, 0);
    check("mid_reset_len", RX_MSG_LEN, 0);
    tx_active = 1'b0;
    rx_active = 1'b0;
    RX_REQ = 1'b0;
    RX_PEND = 1'b0;
    m_ptr = 0;
    repeat (2) tick();
    RESETn = 1'b1;
    tick();
    tx_msg(32'h71, 3, 1'b0, -1, 1'b0);
    rx_msg(32'h72, 1'b0, 1, 1'b0, $urandom, $urandom);

    // Randomized traffic with TX and RX overlapping.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 2) == 0) txb_op(1'b1, 1'b0, '0, 1'b0);
      n_wr = $urandom_range(0, DEPTH + 2);
      repeat (n_wr) txb_op(1'b0, 1'b1, $urandom, 1'b0);
      case ($urandom_range(0, 9))
        0:       len = 0;
        1:       len = DEPTH + 1;
        default: len = $urandom_range(1, DEPTH);
      endcase
      fw = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      rf = $urandom_range(0, 1) == 1;
      rn = $urandom_range(0, DEPTH + 2);
      rxf = (rn == 0) || ($urandom_range(0, 4) == 0);
      rb = $urandom_range(0, 1) == 1;
      ra = $urandom;
      fork
        tx_msg($urandom, len, $urandom_range(0, 1) == 1, fw, rf);
        rx_msg(ra, rb, rn, rxf, $urandom, $urandom);
      join
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
